// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave                                                       |
// | Purpose  : APB-programmed SPI slave, 8-bit MSB-first frames, all four      |
// |            CPOL/CPHA modes, TX/RX byte FIFOs and a sticky status register. |
// | Ports    : PCLK, nREST              clock / async active-low reset         |
// |            PSEL..PWDATA, PRDATA     APB slave (zero wait states)           |
// |            PREADY, PSLVERR          tied 1 / 0                             |
// |            spi_int                  ie & done                              |
// |            pad_spi_*                SPI pads (CS active-low, MISO oen low) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_slave #(
  parameter logic [31:0] ADDR_SPISCR = 32'h40004040,
  parameter logic [31:0] ADDR_SPISSR = 32'h40004044,
  parameter logic [31:0] ADDR_SPISDR = 32'h40004048,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        PCLK,
  input  logic        nREST,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        spi_int,
  input  logic        pad_spi_sck_in,
  input  logic        pad_spi_cs_in,
  input  logic        pad_spi_mosi_in,
  output logic        pad_spi_miso_out,
  output logic        pad_spi_miso_oen
);

  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_LAST) ? '0 : p + c_PW'(1);
  endfunction

  // APB decode
  logic w_apb_wr, w_apb_rd, w_sel_scr, w_sel_ssr, w_sel_sdr, w_unused_pwdata;
  assign w_apb_wr  = PSEL & ~PENABLE & PWRITE;
  assign w_apb_rd  = PSEL & PENABLE & ~PWRITE;
  assign w_sel_scr = (PADDR == ADDR_SPISCR);
  assign w_sel_ssr = (PADDR == ADDR_SPISSR);
  assign w_sel_sdr = (PADDR == ADDR_SPISDR);
  assign w_unused_pwdata = ^PWDATA[31:8];
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  // Control register
  logic r_ie, r_en, r_cpol, r_cpha;
  always_ff @(posedge PCLK or negedge nREST) begin
    if (!nREST) begin
      {r_cpha, r_cpol, r_en, r_ie} <= 4'b0;
    end else if (w_apb_wr && w_sel_scr) begin
      {r_cpha, r_cpol, r_en, r_ie} <= {PWDATA[4], PWDATA[3], PWDATA[1], PWDATA[0]};
    end
  end

  // Pad synchronizers; idle levels are CS high, SCK low
  logic [1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic       r_sck_d, r_cs_d;
  logic       w_sck_s, w_cs_s, w_mosi_s;
  always_ff @(posedge PCLK or negedge nREST) begin
    if (!nREST) begin
      r_sck_sync  <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], pad_spi_sck_in};
      r_cs_sync   <= {r_cs_sync[0], pad_spi_cs_in};
      r_mosi_sync <= {r_mosi_sync[0], pad_spi_mosi_in};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
    end
  end
  assign w_sck_s  = r_sck_sync[1];
  assign w_cs_s   = r_cs_sync[1];
  assign w_mosi_s = r_mosi_sync[1];

  logic w_cs_fall, w_lead, w_trail, w_shift_edge, w_sample_edge;
  assign w_cs_fall     = ~w_cs_s & r_cs_d;
  // Leading edge moves SCK away from its CPOL idle level
  assign w_lead        = r_cpol ? (~w_sck_s & r_sck_d) : (w_sck_s & ~r_sck_d);
  assign w_trail       = r_cpol ? (w_sck_s & ~r_sck_d) : (~w_sck_s & r_sck_d);
  assign w_shift_edge  = r_cpha ? w_lead : w_trail;
  assign w_sample_edge = r_cpha ? w_trail : w_lead;

  state_t     r_state;
  logic [7:0] r_tx_shreg, r_rx_shreg;
  logic [3:0] r_bit_cnt;
  logic       r_skip;
  logic       r_done, r_overrun, r_underrun, r_frame_err;

  // TX FIFO: APB pushes, FSM pops
  logic [7:0]      r_tx_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_tx_wp, r_tx_rp;
  logic [c_CW-1:0] r_tx_cnt;
  logic            w_tx_full, w_tx_empty, w_tx_push, w_tx_req, w_tx_pop;
  logic [7:0]      w_tx_byte;
  assign w_tx_full  = (r_tx_cnt == c_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = w_apb_wr & w_sel_sdr & ~w_tx_full;
  assign w_tx_req   = r_en & (((r_state == IDLE) & w_cs_fall) | ((r_state == DONE) & ~w_cs_s));
  assign w_tx_pop   = w_tx_req & ~w_tx_empty;
  assign w_tx_byte  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];

  // RX FIFO: FSM pushes, APB data reads pop
  logic [7:0]      r_rx_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_rx_wp, r_rx_rp;
  logic [c_CW-1:0] r_rx_cnt;
  logic            w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  assign w_rx_full  = (r_rx_cnt == c_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_push  = r_en & (r_state == DONE) & ~w_rx_full;
  assign w_rx_pop   = w_apb_rd & w_sel_sdr & ~w_rx_empty;

  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= PWDATA[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shreg;
  end

  always_ff @(posedge PCLK or negedge nREST) begin
    if (!nREST) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= f_inc(r_tx_wp);
      if (w_tx_pop)  r_tx_rp <= f_inc(r_tx_rp);
      if (w_rx_push) r_rx_wp <= f_inc(r_rx_wp);
      if (w_rx_pop)  r_rx_rp <= f_inc(r_rx_rp);
      r_tx_cnt <= r_tx_cnt + c_CW'(w_tx_push) - c_CW'(w_tx_pop);
      r_rx_cnt <= r_rx_cnt + c_CW'(w_rx_push) - c_CW'(w_rx_pop);
    end
  end

  // Frame FSM and status flags. Flag clears come first so a set in the
  // same cycle overrides them.
  always_ff @(posedge PCLK or negedge nREST) begin
    if (!nREST) begin
      r_state     <= IDLE;
      r_tx_shreg  <= 8'h00;
      r_rx_shreg  <= 8'h00;
      r_bit_cnt   <= 4'd0;
      r_skip      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_apb_wr && w_sel_ssr) begin
        if (PWDATA[0]) r_done      <= 1'b0;
        if (PWDATA[1]) r_overrun   <= 1'b0;
        if (PWDATA[2]) r_underrun  <= 1'b0;
        if (PWDATA[3]) r_frame_err <= 1'b0;
      end
      if (!r_en) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall) begin
              r_tx_shreg <= w_tx_byte;
              if (w_tx_empty) r_underrun <= 1'b1;
              r_bit_cnt  <= 4'd8;
              // CPHA=1: MISO already shows bit 7, so the first leading edge must not shift
              r_skip     <= r_cpha;
              r_state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_cs_s) begin
              // A CS rise before any bit is sampled just ends a back-to-back
              // run; only a truncated frame is an error.
              if (r_bit_cnt != 4'd8) r_frame_err <= 1'b1;
              r_state <= IDLE;
            end else begin
              if (w_shift_edge) begin
                if (r_skip) r_skip     <= 1'b0;
                else        r_tx_shreg <= {r_tx_shreg[6:0], 1'b0};
              end
              if (w_sample_edge) begin
                r_rx_shreg <= {r_rx_shreg[6:0], w_mosi_s};
                r_bit_cnt  <= r_bit_cnt - 4'd1;
                if (r_bit_cnt == 4'd1) r_state <= DONE;
              end
            end
          end
          DONE: begin
            r_done <= 1'b1;
            if (w_rx_full) r_overrun <= 1'b1;
            if (!w_cs_s) begin
              r_tx_shreg <= w_tx_byte;
              if (w_tx_empty) r_underrun <= 1'b1;
              r_bit_cnt  <= 4'd8;
              // CPHA=1 skips the first leading edge; CPHA=0 skips the trailing
              // edge of the previous frame's last bit, still to come.
              r_skip     <= 1'b1;
              r_state    <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign spi_int          = r_ie & r_done;
  assign pad_spi_miso_out = r_tx_shreg[7];
  assign pad_spi_miso_oen = ~(~w_cs_s & r_en);

  always_comb begin
    PRDATA = 32'h0;
    if (w_sel_scr)
      PRDATA = {24'b0, 3'b0, r_cpha, r_cpol, 1'b0, r_en, r_ie};
    else if (w_sel_ssr)
      PRDATA = {24'b0, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full,
                r_frame_err, r_underrun, r_overrun, r_done};
    else if (w_sel_sdr)
      PRDATA = {24'b0, (w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp])};
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: PCLK (all logic on rising edge) and nREST.
REQ-002 Parameters (name, default, meaning):
  ADDR_SPISCR, 32'h40004040, control register address.
  ADDR_SPISSR, 32'h40004044, status register address.
  ADDR_SPISDR, 32'h40004048, data register address.
  FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs.
REQ-003 Ports (name, direction, width, meaning):
  PCLK  in  1  system clock.
  nREST  in  1  async active-low reset.
  PSEL, PENABLE, PWRITE  in  1 each  APB control.
  PADDR, PWDATA  in  32 each  APB address and write data.
  PRDATA  out  32  APB read data.
  PREADY  out  1  tied 1.
  PSLVERR  out  1  tied 0.
  spi_int  out  1  interrupt = SPISCR.ie & SPISSR.done.
  pad_spi_sck_in, pad_spi_cs_in, pad_spi_mosi_in  in  1 each  SPI from master; CS is active-low.
  pad_spi_miso_out  out  1  SPI data to master.
  pad_spi_miso_oen  out  1  active-low output enable.

Function
REQ-004 APB write SHALL occur in the setup phase (PSEL & ~PENABLE & PWRITE) with zero wait states; unmapped addresses SHALL be ignored.
REQ-005 PRDATA SHALL be combinational: {24'b0, register} for mapped addresses and 0 otherwise.
REQ-006 An RX FIFO pop SHALL occur exactly once per read of SPISDR, in the access phase (PSEL & PENABLE & ~PWRITE).
REQ-007 SPISCR bits SHALL be [0] ie, [1] en, [3] CPOL, [4] CPHA; all other bits read 0.
REQ-008 SPISSR bits SHALL be [0] done, [1] overrun, [2] underrun, [3] frame_err, [4] tx_full, [5] tx_empty, [6] rx_full, [7] rx_empty.
REQ-009 SPISSR [3:0] SHALL be write-1-to-clear; a set event in the same cycle as a clear SHALL win.
REQ-010 A write to SPISDR SHALL push PWDATA[7:0] into the TX FIFO; if the FIFO is full, the data SHALL be dropped and no flag set.
REQ-011 SCK, CS and MOSI SHALL pass through 2-flop synchronizers, and edges SHALL be detected on the synchronized SCK; supported SCK is at most PCLK/8.
REQ-012 The SCK leading edge SHALL be the edge away from CPOL; the trailing edge SHALL be the edge back to CPOL.
REQ-013 Data SHALL be 8-bit frames, MSB first.
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 In IDLE with en=1, synchronized CS falling SHALL cause, in one cycle: pop of the TX FIFO into the shift register (0x00 and underrun set if empty), bit_cnt=8, and a transition to SHIFT.
REQ-016 pad_spi_miso_oen SHALL be 0 while synchronized CS is low and en=1, and 1 otherwise; pad_spi_miso_out SHALL be shreg[7].
REQ-017 With CPHA=0, MISO SHALL present bit 7 at CS fall, sample MOSI on the leading edge, and shift on the trailing edge.
REQ-018 With CPHA=1, the slave SHALL shift on the leading edge (except the first leading edge) and sample on the trailing edge.
REQ-019 When the 8th sample is taken, the FSM SHALL go to DONE.
REQ-020 For one cycle in DONE, the received byte SHALL be pushed to the RX FIFO and done set; if the RX FIFO is full, the byte SHALL be discarded and overrun set.
REQ-021 From DONE: with CS still low, a new TX pop SHALL occur and the FSM SHALL re-enter SHIFT for a back-to-back frame; with CS high, the FSM SHALL return to IDLE.
REQ-022 CS rising in SHIFT SHALL abort the frame: partial data discarded, frame_err set, FSM to IDLE, and the TX byte not re-queued.
REQ-023 en=0 SHALL force the FSM to IDLE within one cycle; FIFO contents SHALL be preserved.
REQ-024 A simultaneous APB push/pop and SPI pop/push on the same FIFO SHALL both take effect, leaving the count unchanged.

Reset
REQ-025 On nREST low, all registers SHALL reset immediately: SPISCR=0, flags=0, FIFOs empty, FSM=IDLE, synchronizers to idle (CS=1, SCK=0), miso_oen=1, miso_out=0, spi_int=0.
REQ-026 Reset asserted mid-frame SHALL discard the frame with no flags set after release.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  Mode 0, TX FIFO holds 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RX reads 0x3C; done=1; spi_int=1 when ie=1.
  Mode 3, two back-to-back frames with CS held low, TX 0x12 and 0x34 -> master receives 0x12 then 0x34; RX holds two entries.
  Frame with TX FIFO empty -> MISO all 0; underrun=1; write 0x04 to SPISSR -> underrun=0.
  5 frames with no reads -> rx_full=1; overrun=1; first 4 bytes read back in order.
  CS raised after 3 bits -> frame_err=1; rx_empty stays 1; next full frame received correctly.
  nREST pulsed mid-frame -> all outputs at reset values; SPISSR reads 0xA0.
